// File: rtl/fetch_unit.sv
// fetch_unit: two-entry instruction prefetch buffer in front of a single-outstanding memory port.
// Define FETCH_BYPASS_EN to forward mem_rdata to instr when the buffer is empty and the ack hits pc.
module fetch_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   // Handshake: a read transfers on the edge where mem_req and mem_ack are both high; mem_req stays
   // high and mem_addr stable until then, and mem_ack without mem_req is ignored. The data path
   // consumes instr on every edge where instr_valid is high (no back-pressure).

   // DRAIN is the "drop" condition: the outstanding read belongs to a flushed stream.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [29:0] req_addr_q, req_addr_d;

   // Entry 0 is the head; entries are kept compacted, so v1 implies v0.
   logic        v0_q, v1_q, v0_d, v1_d;
   logic [29:0] a0_q, a1_q, a0_d, a1_d;
   logic [31:0] d0_q, d1_q, d0_d, d1_d;

   logic [29:0] pc_word;
   logic        hit, flush, ack, bypass, fill;
   logic [29:0] start_addr;
   logic        pc_unused;

   assign pc_word   = pc[31:2];
   assign pc_unused = ^pc[1:0];
   assign hit       = v0_q && (a0_q == pc_word);
   assign flush     = v0_q && (a0_q != pc_word);
   assign mem_req   = (state_q != IDLE);
   assign mem_addr  = {req_addr_q, 2'b00};
   assign ack       = mem_req && mem_ack;

`ifdef FETCH_BYPASS_EN
   assign bypass = (state_q == FETCH) && !v0_q && mem_ack && (req_addr_q == pc_word);
`else
   assign bypass = 1'b0;
`endif

   assign instr_valid = hit || bypass;
   assign instr       = hit ? d0_q : (bypass ? mem_rdata : 32'h0);

   always_comb begin
      state_d    = state_q;
      req_addr_d = req_addr_q;
      v0_d       = v0_q;
      a0_d       = a0_q;
      d0_d       = d0_q;
      v1_d       = v1_q;
      a1_d       = a1_q;
      d1_d       = d1_q;
      fill       = 1'b0;
      start_addr = pc_word;

      if (flush) begin
         v0_d = 1'b0;
         v1_d = 1'b0;
      end else if (hit) begin
         v0_d = v1_q;
         a0_d = a1_q;
         d0_d = d1_q;
         v1_d = 1'b0;
      end

      fill = ack && (state_q == FETCH) && !flush && !bypass;
      if (fill) begin
         if (!v0_d) begin
            v0_d = 1'b1;
            a0_d = req_addr_q;
            d0_d = mem_rdata;
         end else begin
            v1_d = 1'b1;
            a1_d = req_addr_q;
            d1_d = mem_rdata;
         end
      end

      // Continue after the newest word known to the buffer; restart at pc when the stream breaks.
      if (flush)
         start_addr = pc_word;
      else if (fill || bypass)
         start_addr = req_addr_q + 30'd1;
      else if (v1_q)
         start_addr = a1_q + 30'd1;
      else if (v0_q)
         start_addr = a0_q + 30'd1;
      else
         start_addr = pc_word;

      case (state_q)
         IDLE: begin
            if (!v1_d) begin
               state_d    = FETCH;
               req_addr_d = start_addr;
            end
         end
         FETCH: begin
            if (ack) begin
               if (!v1_d) begin
                  state_d    = FETCH;
                  req_addr_d = start_addr;
               end else begin
                  state_d = IDLE;
               end
            end else if (flush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (ack) begin
               state_d    = FETCH;
               req_addr_d = start_addr;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         req_addr_q <= '0;
         v0_q       <= 1'b0;
         v1_q       <= 1'b0;
         a0_q       <= '0;
         a1_q       <= '0;
         d0_q       <= '0;
         d1_q       <= '0;
      end else begin
         state_q    <= state_d;
         req_addr_q <= req_addr_d;
         v0_q       <= v0_d;
         v1_q       <= v1_d;
         a0_q       <= a0_d;
         a1_q       <= a1_d;
         d0_q       <= d0_d;
         d1_q       <= d1_d;
      end
   end

endmodule
